easyaxi_rd_mst_rob: RTL and testbench
=====================================

Name: easyaxi_rd_mst_rob

Overview:
- Parametrised next-generation AXI read master, driven by an external descriptor interface instead of hard-coded bursts.
- Holds up to OST_DEPTH outstanding reads, each given a unique ARID equal to its entry index.
- Collects burst data from R beats that may arrive out of order across IDs.
- Returns completed bursts on a result interface strictly in request-acceptance order (reorder buffer).
- Sits between a traffic/DMA controller and the AXI interconnect.

Parameters:
- OST_DEPTH, 8: number of reorder entries; power of 2, at least 2.
- ADDR_W, 32: address width.
- DATA_W, 32: R data width.
- MAX_BURST_LEN, 8: maximum beats per burst; power of 2.
- ID_W (localparam), clog2(OST_DEPTH): ARID/RID width.
- LEN_W, 8: AXI length width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  descriptor valid
- req_ready  out  1  descriptor accepted when high with req_valid
- req_addr  in  ADDR_W  start address
- req_len  in  LEN_W  beats-1
- req_size  in  3  AXI size
- req_burst  in  2  AXI burst type
- axi_mst_arvalid/arready  out/in  1  AR handshake
- axi_mst_arid  out  ID_W  entry index
- axi_mst_araddr, arlen, arsize, arburst  out  ADDR_W/LEN_W/3/2  AR payload
- axi_mst_rvalid  in  1  R valid
- axi_mst_rready  out  1  R ready
- axi_mst_rid  in  ID_W  R ID
- axi_mst_rdata  in  DATA_W  R data
- axi_mst_rresp  in  2  R response
- axi_mst_rlast  in  1  R last beat
- res_valid/res_ready  out/in  1  result handshake
- res_data  out  DATA_W*MAX_BURST_LEN  beat k in bits [k*DATA_W +: DATA_W]; unused beats zero
- res_beats  out  clog2(MAX_BURST_LEN)+1  beats received
- res_resp  out  2  worst response across beats
- res_err  out  1  res_resp is SLVERR/DECERR or descriptor was illegal
- prot_err  out  1  sticky protocol-violation flag
- idle  out  1  no entries allocated

Behaviour:
Reset:
- rst_n is asynchronous, active-low; clk is the clock.
- On reset, all pointers, count, entry state, data and prot_err clear.
- Outputs after reset: req_ready=1, arvalid=0, res_valid=0, idle=1, rready=1.

Entry state and allocation:
- Each entry has state FREE→ALLOC→ISSUED→DONE→FREE, plus a bad flag.
- Allocation is in-order at alloc_ptr, issue at issue_ptr, retire at ret_ptr. All three pointers wrap modulo OST_DEPTH.
- req_ready = (count < OST_DEPTH); it does not depend on a same-cycle retire.
- Allocate on req_valid&req_ready: capture payload, zero data/beats/resp, alloc_ptr+1.
- If req_len >= MAX_BURST_LEN, the entry is marked bad and goes straight to DONE with res_resp=2'b10, res_err=1, res_beats=0. It is never issued.

AR issue:
- axi_mst_arvalid = entry[issue_ptr] in ALLOC and not bad. Payload comes from that entry; arid = issue_ptr.
- AR payload holds stable while arvalid is high and arready is low.
- On handshake: entry→ISSUED, issue_ptr+1.
- A bad entry at issue_ptr is skipped: issue_ptr+1 with no AR (one-cycle bubble).
- Earliest arvalid is the cycle after req acceptance.

R collection:
- rready is tied 1.
- On an R beat, entry = rid:
  - data is written to slot beat_cnt; beat_cnt+1;
  - resp is updated to max(resp, rresp).
- rlast → entry DONE.

Protocol errors (set prot_err, sticky until reset):
- rid entry is not ISSUED: beat dropped.
- beat_cnt already = len+1: beat dropped.
- beat number len+1 arrives without rlast: entry forced DONE.

Retire:
- res_valid = entry[ret_ptr] DONE; outputs are driven from that entry.
- On res_valid&res_ready: entry FREE, ret_ptr+1, count-1.
- Earliest res_valid is the cycle after rlast.
- The result holds stable while res_ready is low.
- Out-of-order completion waits at DONE until older entries retire.

Simultaneous events and reset:
- Same-cycle allocate, AR issue, R beat and retire are all legal, including on the same entry's different fields.
- count updates by +alloc−retire.
- Reset mid-burst discards all state. Post-reset stray R beats flag prot_err.

idle = (count == 0).

Decomposition:
- easyaxi_pkg: AXI resp/burst/size encodings, entry-state enum, response-max helper function.
- One natural sub-module: easyaxi_rob_entry, holding per-entry state, payload, beat counter and data slots. Instantiated OST_DEPTH times in a generate loop.
- Pointers and count stay in the top level.

Test Plan:
- 1 request (addr 0x100, len 3, INCR, size 2); slave returns 4 beats 0xA0..0xA3 OKAY → arid 0; one result with res_beats 4, data {A3,A2,A1,A0}, res_resp 0, res_err 0.
- 8 requests (ids 0-7) with arready held high; slave answers in reverse id order → req_ready low after 8th; results emitted in ids 0..7 order; first res_valid only after id 0 rlast.
- req_len 8 with MAX_BURST_LEN 8, sandwiched between two legal requests → no AR for bad entry; results in order: ok, (res_err 1, res_resp 2, res_beats 0), ok.
- Burst len 3 with beat 2 rresp SLVERR → res_resp 2, res_err 1, all 4 beats stored.
- R beat with rid of a FREE entry, and a 5th beat on a len 3 burst → prot_err=1, stored results unchanged.
- res_ready held low with 8 DONE entries, then a new request → req_ready 0 and no AR; release res_ready → one retire per cycle; assert rst_n low mid-burst → all outputs return to reset values next edge.

Source files
------------

// File: rtl/easyaxi_pkg.sv
// rtl/easyaxi_pkg.sv - AXI encodings, reorder-entry state and response helpers
package easyaxi_pkg;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_ALLOC  = 2'd1,
    ST_ISSUED = 2'd2,
    ST_DONE   = 2'd3
  } entry_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_1B  = 3'd0;
  localparam logic [2:0] SIZE_2B  = 3'd1;
  localparam logic [2:0] SIZE_4B  = 3'd2;
  localparam logic [2:0] SIZE_8B  = 3'd3;

  // Encodings are ordered by severity, so the worst response is the numeric max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic resp_is_err(input logic [1:0] r);
    return r[1];
  endfunction

endpackage

// File: rtl/easyaxi_rd_mst_rob_if.sv
// rtl/easyaxi_rd_mst_rob_if.sv - descriptor, AXI read and result bundle
interface easyaxi_rd_mst_rob_if #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 8,
  parameter int LEN_W         = 8,
  parameter int ID_W          = 3
);
  localparam int BEATS_W = $clog2(MAX_BURST_LEN) + 1;

  logic                            req_valid;
  logic                            req_ready;
  logic [ADDR_W-1:0]               req_addr;
  logic [LEN_W-1:0]                req_len;
  logic [2:0]                      req_size;
  logic [1:0]                      req_burst;

  logic                            axi_mst_arvalid;
  logic                            axi_mst_arready;
  logic [ID_W-1:0]                 axi_mst_arid;
  logic [ADDR_W-1:0]               axi_mst_araddr;
  logic [LEN_W-1:0]                axi_mst_arlen;
  logic [2:0]                      axi_mst_arsize;
  logic [1:0]                      axi_mst_arburst;

  logic                            axi_mst_rvalid;
  logic                            axi_mst_rready;
  logic [ID_W-1:0]                 axi_mst_rid;
  logic [DATA_W-1:0]               axi_mst_rdata;
  logic [1:0]                      axi_mst_rresp;
  logic                            axi_mst_rlast;

  logic                            res_valid;
  logic                            res_ready;
  logic [DATA_W*MAX_BURST_LEN-1:0] res_data;
  logic [BEATS_W-1:0]              res_beats;
  logic [1:0]                      res_resp;
  logic                            res_err;

  modport master (
    input  req_valid, req_addr, req_len, req_size, req_burst,
    output req_ready,
    output axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
           axi_mst_arsize, axi_mst_arburst,
    input  axi_mst_arready,
    input  axi_mst_rvalid, axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    output axi_mst_rready,
    output res_valid, res_data, res_beats, res_resp, res_err,
    input  res_ready
  );

  modport slave (
    output req_valid, req_addr, req_len, req_size, req_burst,
    input  req_ready,
    input  axi_mst_arvalid, axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
           axi_mst_arsize, axi_mst_arburst,
    output axi_mst_arready,
    output axi_mst_rvalid, axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast,
    input  axi_mst_rready,
    input  res_valid, res_data, res_beats, res_resp, res_err,
    output res_ready
  );

endinterface

// File: rtl/easyaxi_rob_entry.sv
// rtl/easyaxi_rob_entry.sv - one reorder slot: lifecycle, AR payload, beat collection
module easyaxi_rob_entry
  import easyaxi_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 8,
  parameter int LEN_W         = 8,
  localparam int IDX_W        = $clog2(MAX_BURST_LEN),
  localparam int BEATS_W      = IDX_W + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_i,
  input  logic [ADDR_W-1:0]               req_addr_i,
  input  logic [LEN_W-1:0]                req_len_i,
  input  logic [2:0]                      req_size_i,
  input  logic [1:0]                      req_burst_i,
  input  logic                            issue_i,
  input  logic                            beat_i,
  input  logic [DATA_W-1:0]               rdata_i,
  input  logic [1:0]                      rresp_i,
  input  logic                            rlast_i,
  input  logic                            retire_i,
  output entry_state_e                    state_o,
  output logic                            bad_o,
  output logic [ADDR_W-1:0]               addr_o,
  output logic [LEN_W-1:0]                len_o,
  output logic [2:0]                      size_o,
  output logic [1:0]                      burst_o,
  output logic [DATA_W*MAX_BURST_LEN-1:0] data_o,
  output logic [BEATS_W-1:0]              beats_o,
  output logic [1:0]                      resp_o,
  output logic                            beat_err_o
);

  entry_state_e                    state_q, state_d;
  logic                            bad_q, bad_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [2:0]                      size_q, size_d;
  logic [1:0]                      burst_q, burst_d;
  logic [DATA_W*MAX_BURST_LEN-1:0] data_q, data_d;
  logic [BEATS_W-1:0]              beat_cnt_q, beat_cnt_d;
  logic [1:0]                      resp_q, resp_d;
  logic                            full, final_beat;

  always_comb begin
    state_d    = state_q;
    bad_d      = bad_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    data_d     = data_q;
    beat_cnt_d = beat_cnt_q;
    resp_d     = resp_q;
    beat_err_o = 1'b0;
    // Legal entries have len < MAX_BURST_LEN, so len always fits the beat counter.
    full       = (beat_cnt_q == BEATS_W'(len_q) + BEATS_W'(1));
    final_beat = (beat_cnt_q == BEATS_W'(len_q));

    if (alloc_i) begin
      addr_d     = req_addr_i;
      len_d      = req_len_i;
      size_d     = req_size_i;
      burst_d    = req_burst_i;
      data_d     = '0;
      beat_cnt_d = '0;
      if ({1'b0, req_len_i} >= (LEN_W+1)'(MAX_BURST_LEN)) begin
        bad_d   = 1'b1;
        state_d = ST_DONE;
        resp_d  = RESP_SLVERR;
      end else begin
        bad_d   = 1'b0;
        state_d = ST_ALLOC;
        resp_d  = RESP_OKAY;
      end
    end else begin
      if (retire_i) begin
        state_d = ST_FREE;
        bad_d   = 1'b0;
      end
      if (issue_i) begin
        state_d = ST_ISSUED;
      end
      if (beat_i) begin
        if (state_q != ST_ISSUED || full) begin
          beat_err_o = 1'b1;
        end else begin
          data_d[beat_cnt_q[IDX_W-1:0]*DATA_W +: DATA_W] = rdata_i;
          beat_cnt_d = beat_cnt_q + BEATS_W'(1);
          resp_d     = resp_max(resp_q, rresp_i);
          if (rlast_i || final_beat) begin
            state_d = ST_DONE;
          end
          if (final_beat && !rlast_i) begin
            beat_err_o = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FREE;
      bad_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      data_q     <= '0;
      beat_cnt_q <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      bad_q      <= bad_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      data_q     <= data_d;
      beat_cnt_q <= beat_cnt_d;
      resp_q     <= resp_d;
    end
  end

  assign state_o = state_q;
  assign bad_o   = bad_q;
  assign addr_o  = addr_q;
  assign len_o   = len_q;
  assign size_o  = size_q;
  assign burst_o = burst_q;
  assign data_o  = data_q;
  assign beats_o = beat_cnt_q;
  assign resp_o  = resp_q;

endmodule

// File: rtl/easyaxi_rd_mst_rob.sv
// rtl/easyaxi_rd_mst_rob.sv - descriptor-driven AXI read master with in-order result reorder buffer
module easyaxi_rd_mst_rob
  import easyaxi_pkg::*;
#(
  parameter int OST_DEPTH     = 8,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 8,
  parameter int LEN_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  easyaxi_rd_mst_rob_if.master   bus,
  output logic                   prot_err,
  output logic                   idle
);

  localparam int ID_W    = $clog2(OST_DEPTH);
  localparam int CNT_W   = ID_W + 1;
  localparam int BEATS_W = $clog2(MAX_BURST_LEN) + 1;

  logic [ID_W-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [ID_W-1:0]  issue_ptr_q, issue_ptr_d;
  logic [ID_W-1:0]  ret_ptr_q, ret_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             prot_err_q, prot_err_d;
  logic             do_alloc, do_issue, do_skip, do_retire;

  logic [OST_DEPTH-1:0] alloc_vec, issue_vec, beat_vec, retire_vec, beat_err_vec;

  entry_state_e                    e_state [OST_DEPTH];
  logic                            e_bad   [OST_DEPTH];
  logic [ADDR_W-1:0]               e_addr  [OST_DEPTH];
  logic [LEN_W-1:0]                e_len   [OST_DEPTH];
  logic [2:0]                      e_size  [OST_DEPTH];
  logic [1:0]                      e_burst [OST_DEPTH];
  logic [DATA_W*MAX_BURST_LEN-1:0] e_data  [OST_DEPTH];
  logic [BEATS_W-1:0]              e_beats [OST_DEPTH];
  logic [1:0]                      e_resp  [OST_DEPTH];

  always_comb begin
    bus.req_ready = (count_q < CNT_W'(OST_DEPTH));
    do_alloc      = bus.req_valid && bus.req_ready;

    bus.axi_mst_arvalid = (e_state[issue_ptr_q] == ST_ALLOC) && !e_bad[issue_ptr_q];
    bus.axi_mst_arid    = issue_ptr_q;
    bus.axi_mst_araddr  = e_addr[issue_ptr_q];
    bus.axi_mst_arlen   = e_len[issue_ptr_q];
    bus.axi_mst_arsize  = e_size[issue_ptr_q];
    bus.axi_mst_arburst = e_burst[issue_ptr_q];
    do_issue            = bus.axi_mst_arvalid && bus.axi_mst_arready;
    // Illegal descriptors land directly in DONE; the issue pointer steps over them.
    do_skip             = (e_state[issue_ptr_q] == ST_DONE) && e_bad[issue_ptr_q];

    bus.axi_mst_rready = 1'b1;

    bus.res_valid = (e_state[ret_ptr_q] == ST_DONE);
    bus.res_data  = e_data[ret_ptr_q];
    bus.res_beats = e_beats[ret_ptr_q];
    bus.res_resp  = e_resp[ret_ptr_q];
    bus.res_err   = resp_is_err(e_resp[ret_ptr_q]) || e_bad[ret_ptr_q];
    do_retire     = bus.res_valid && bus.res_ready;

    for (int i = 0; i < OST_DEPTH; i++) begin
      alloc_vec[i]  = do_alloc  && (alloc_ptr_q == ID_W'(i));
      issue_vec[i]  = do_issue  && (issue_ptr_q == ID_W'(i));
      retire_vec[i] = do_retire && (ret_ptr_q   == ID_W'(i));
      beat_vec[i]   = bus.axi_mst_rvalid && (bus.axi_mst_rid == ID_W'(i));
    end

    alloc_ptr_d = alloc_ptr_q + ID_W'(do_alloc);
    issue_ptr_d = issue_ptr_q + ID_W'(do_issue || do_skip);
    ret_ptr_d   = ret_ptr_q + ID_W'(do_retire);
    count_d     = count_q + CNT_W'(do_alloc) - CNT_W'(do_retire);
    prot_err_d  = prot_err_q || (|beat_err_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      issue_ptr_q <= '0;
      ret_ptr_q   <= '0;
      count_q     <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      issue_ptr_q <= issue_ptr_d;
      ret_ptr_q   <= ret_ptr_d;
      count_q     <= count_d;
      prot_err_q  <= prot_err_d;
    end
  end

  for (genvar g = 0; g < OST_DEPTH; g++) begin : g_entry
    easyaxi_rob_entry #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .MAX_BURST_LEN (MAX_BURST_LEN),
      .LEN_W         (LEN_W)
    ) u_entry (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc_i     (alloc_vec[g]),
      .req_addr_i  (bus.req_addr),
      .req_len_i   (bus.req_len),
      .req_size_i  (bus.req_size),
      .req_burst_i (bus.req_burst),
      .issue_i     (issue_vec[g]),
      .beat_i      (beat_vec[g]),
      .rdata_i     (bus.axi_mst_rdata),
      .rresp_i     (bus.axi_mst_rresp),
      .rlast_i     (bus.axi_mst_rlast),
      .retire_i    (retire_vec[g]),
      .state_o     (e_state[g]),
      .bad_o       (e_bad[g]),
      .addr_o      (e_addr[g]),
      .len_o       (e_len[g]),
      .size_o      (e_size[g]),
      .burst_o     (e_burst[g]),
      .data_o      (e_data[g]),
      .beats_o     (e_beats[g]),
      .resp_o      (e_resp[g]),
      .beat_err_o  (beat_err_vec[g])
    );
  end

  assign prot_err = prot_err_q;
  assign idle     = (count_q == '0);

endmodule

// File: tb/tb_easyaxi_rd_mst_rob.sv
// tb/tb_easyaxi_rd_mst_rob.sv - directed self-checking bench for the reorder-buffer read master
module tb_easyaxi_rd_mst_rob;
  import easyaxi_pkg::*;

  localparam int DW = 32;
  localparam int MB = 8;
  localparam int RW = DW * MB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prot_err, idle;
  int   n_checks = 0;
  int   n_errors = 0;

  easyaxi_rd_mst_rob_if #(.ADDR_W(32), .DATA_W(DW), .MAX_BURST_LEN(MB), .LEN_W(8), .ID_W(3)) bus ();

  easyaxi_rd_mst_rob #(.OST_DEPTH(8), .ADDR_W(32), .DATA_W(DW), .MAX_BURST_LEN(MB), .LEN_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .prot_err (prot_err),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  logic [2:0]    mon_arid [$];
  logic [31:0]   mon_araddr [$];
  logic [7:0]    mon_arlen [$];
  logic [RW-1:0] mon_rdata [$];
  logic [3:0]    mon_rbeats [$];
  logic [1:0]    mon_rresp [$];
  logic          mon_rerr [$];

  // Inputs change just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (rst_n && bus.axi_mst_arvalid && bus.axi_mst_arready) begin
      mon_arid.push_back(bus.axi_mst_arid);
      mon_araddr.push_back(bus.axi_mst_araddr);
      mon_arlen.push_back(bus.axi_mst_arlen);
    end
    if (rst_n && bus.res_valid && bus.res_ready) begin
      mon_rdata.push_back(bus.res_data);
      mon_rbeats.push_back(bus.res_beats);
      mon_rresp.push_back(bus.res_resp);
      mon_rerr.push_back(bus.res_err);
    end
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    bus.axi_mst_rvalid = 1'b0;
    bus.axi_mst_rlast = 1'b0;
    bus.res_ready = 1'b1;
    bus.axi_mst_arready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [7:0] len);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_size  = SIZE_4B;
    bus.req_burst = BURST_INCR;
    while (!bus.req_ready && k < 100) begin
      tick();
      k++;
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic beat(input logic [2:0] id, input logic [31:0] d, input logic [1:0] rr, input logic last);
    bus.axi_mst_rvalid = 1'b1;
    bus.axi_mst_rid    = id;
    bus.axi_mst_rdata  = d;
    bus.axi_mst_rresp  = rr;
    bus.axi_mst_rlast  = last;
    tick();
    bus.axi_mst_rvalid = 1'b0;
    bus.axi_mst_rlast  = 1'b0;
  endtask

  task automatic wait_ar(input int n);
    int k = 0;
    while (mon_arid.size() < n && k < 100) begin
      tick();
      k++;
    end
    check("ar_wait", RW'(mon_arid.size() >= n), RW'(1));
  endtask

  task automatic wait_res(input int n);
    int k = 0;
    while (mon_rdata.size() < n && k < 100) begin
      tick();
      k++;
    end
    check("res_wait", RW'(mon_rdata.size() >= n), RW'(1));
  endtask

  initial begin
    logic [RW-1:0] exp_d;
    int ab, rb;
    bus.req_addr = '0; bus.req_len = '0; bus.req_size = '0; bus.req_burst = '0;
    bus.axi_mst_rid = '0; bus.axi_mst_rdata = '0; bus.axi_mst_rresp = '0;
    do_reset();

    check("rst_req_ready", RW'(bus.req_ready), RW'(1));
    check("rst_arvalid", RW'(bus.axi_mst_arvalid), RW'(0));
    check("rst_res_valid", RW'(bus.res_valid), RW'(0));
    check("rst_idle", RW'(idle), RW'(1));
    check("rst_rready", RW'(bus.axi_mst_rready), RW'(1));
    check("rst_prot_err", RW'(prot_err), RW'(0));

    // single burst, 4 beats
    ab = mon_arid.size(); rb = mon_rdata.size();
    send_req(32'h100, 8'd3);
    check("t1_arvalid_next", RW'(bus.axi_mst_arvalid), RW'(1));
    check("t1_idle", RW'(idle), RW'(0));
    check("t1_arsize", RW'(bus.axi_mst_arsize), RW'(2));
    check("t1_arburst", RW'(bus.axi_mst_arburst), RW'(1));
    wait_ar(ab + 1);
    check("t1_arid", RW'(mon_arid[ab]), RW'(0));
    check("t1_araddr", RW'(mon_araddr[ab]), RW'(32'h100));
    check("t1_arlen", RW'(mon_arlen[ab]), RW'(3));
    for (int i = 0; i < 4; i++) beat(3'd0, 32'hA0 + i, RESP_OKAY, i == 3);
    wait_res(rb + 1);
    exp_d = '0;
    for (int i = 0; i < 4; i++) exp_d[i*DW +: DW] = 32'hA0 + i;
    check("t1_data", mon_rdata[rb], exp_d);
    check("t1_beats", RW'(mon_rbeats[rb]), RW'(4));
    check("t1_resp", RW'(mon_rresp[rb]), RW'(0));
    check("t1_err", RW'(mon_rerr[rb]), RW'(0));

    // 8 outstanding, answered in reverse id order
    do_reset();
    ab = mon_arid.size(); rb = mon_rdata.size();
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = 32'h1000 + 32'(i) * 32'h40;
      bus.req_len = 8'd1; bus.req_size = SIZE_4B; bus.req_burst = BURST_INCR;
      tick();
    end
    bus.req_valid = 1'b0;
    check("t2_req_ready_full", RW'(bus.req_ready), RW'(0));
    wait_ar(ab + 8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_arid%0d", i), RW'(mon_arid[ab+i]), RW'(i));
    check("t2_araddr3", RW'(mon_araddr[ab+3]), RW'(32'h10C0));
    for (int id = 7; id >= 1; id--) begin
      beat(3'(id), 32'(id * 16), RESP_OKAY, 1'b0);
      beat(3'(id), 32'(id * 16 + 1), RESP_OKAY, 1'b1);
    end
    check("t2_no_res_early", RW'(bus.res_valid), RW'(0));
    check("t2_no_res_cnt", RW'(mon_rdata.size()), RW'(rb));
    beat(3'd0, 32'h0, RESP_OKAY, 1'b0);
    beat(3'd0, 32'h1, RESP_OKAY, 1'b1);
    check("t2_res_after_rlast", RW'(bus.res_valid), RW'(1));
    wait_res(rb + 8);
    for (int i = 0; i < 8; i++) begin
      exp_d = '0;
      exp_d[0 +: DW] = 32'(i * 16);
      exp_d[DW +: DW] = 32'(i * 16 + 1);
      check($sformatf("t2_res%0d", i), mon_rdata[rb+i], exp_d);
    end

    // illegal length between two legal requests
    do_reset();
    ab = mon_arid.size(); rb = mon_rdata.size();
    send_req(32'h200, 8'd1);
    send_req(32'h300, 8'd8);
    send_req(32'h400, 8'd1);
    repeat (5) tick();
    check("t3_ar_count", RW'(mon_arid.size() - ab), RW'(2));
    check("t3_arid_a", RW'(mon_arid[ab]), RW'(0));
    check("t3_arid_b", RW'(mon_arid[ab+1]), RW'(2));
    beat(3'd2, 32'hC0, RESP_OKAY, 1'b0);
    beat(3'd2, 32'hC1, RESP_OKAY, 1'b1);
    beat(3'd0, 32'hB0, RESP_OKAY, 1'b0);
    beat(3'd0, 32'hB1, RESP_OKAY, 1'b1);
    wait_res(rb + 3);
    check("t3_r0_data", mon_rdata[rb], RW'(64'h000000B1_000000B0));
    check("t3_r0_err", RW'(mon_rerr[rb]), RW'(0));
    check("t3_bad_err", RW'(mon_rerr[rb+1]), RW'(1));
    check("t3_bad_resp", RW'(mon_rresp[rb+1]), RW'(2));
    check("t3_bad_beats", RW'(mon_rbeats[rb+1]), RW'(0));
    check("t3_bad_data", mon_rdata[rb+1], RW'(0));
    check("t3_r2_data", mon_rdata[rb+2], RW'(64'h000000C1_000000C0));
    check("t3_r2_err", RW'(mon_rerr[rb+2]), RW'(0));

    // SLVERR on beat 2
    do_reset();
    rb = mon_rdata.size();
    send_req(32'h500, 8'd3);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) beat(3'd0, 32'hD0 + i, (i == 2) ? RESP_SLVERR : RESP_OKAY, i == 3);
    wait_res(rb + 1);
    exp_d = '0;
    for (int i = 0; i < 4; i++) exp_d[i*DW +: DW] = 32'hD0 + i;
    check("t4_data", mon_rdata[rb], exp_d);
    check("t4_resp", RW'(mon_rresp[rb]), RW'(2));
    check("t4_err", RW'(mon_rerr[rb]), RW'(1));
    check("t4_beats", RW'(mon_rbeats[rb]), RW'(4));

    // protocol errors: stray rid, extra beat, missing rlast
    do_reset();
    beat(3'd5, 32'hEE, RESP_OKAY, 1'b1);
    check("t5_stray_prot", RW'(prot_err), RW'(1));
    tick();
    check("t5_sticky", RW'(prot_err), RW'(1));
    do_reset();
    rb = mon_rdata.size();
    bus.res_ready = 1'b0;
    send_req(32'h600, 8'd3);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) beat(3'd0, 32'hF0 + i, RESP_OKAY, i == 3);
    check("t5_clean", RW'(prot_err), RW'(0));
    beat(3'd0, 32'hFF, RESP_OKAY, 1'b1);
    check("t5_extra_prot", RW'(prot_err), RW'(1));
    bus.res_ready = 1'b1;
    wait_res(rb + 1);
    exp_d = '0;
    for (int i = 0; i < 4; i++) exp_d[i*DW +: DW] = 32'hF0 + i;
    check("t5_data_kept", mon_rdata[rb], exp_d);
    check("t5_beats_kept", RW'(mon_rbeats[rb]), RW'(4));
    do_reset();
    rb = mon_rdata.size();
    send_req(32'h700, 8'd1);
    repeat (2) tick();
    beat(3'd0, 32'h11, RESP_OKAY, 1'b0);
    beat(3'd0, 32'h22, RESP_OKAY, 1'b0);
    check("t5_norlast_prot", RW'(prot_err), RW'(1));
    wait_res(rb + 1);
    check("t5_norlast_beats", RW'(mon_rbeats[rb]), RW'(2));

    // back-pressure on results, then release, then reset mid-burst
    do_reset();
    ab = mon_arid.size(); rb = mon_rdata.size();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = 32'h2000 + 32'(i) * 32'h4;
      bus.req_len = 8'd0; bus.req_size = SIZE_4B; bus.req_burst = BURST_INCR;
      tick();
    end
    bus.req_valid = 1'b0;
    wait_ar(ab + 8);
    for (int i = 0; i < 8; i++) beat(3'(i), 32'h50 + i, RESP_OKAY, 1'b1);
    tick();
    check("t6_res_valid", RW'(bus.res_valid), RW'(1));
    bus.req_valid = 1'b1; bus.req_addr = 32'h3000; bus.req_len = 8'd0;
    repeat (3) tick();
    check("t6_req_ready", RW'(bus.req_ready), RW'(0));
    check("t6_no_ar", RW'(bus.axi_mst_arvalid), RW'(0));
    check("t6_ar_count", RW'(mon_arid.size() - ab), RW'(8));
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    check("t6_one_retire", RW'(mon_rdata.size() - rb), RW'(1));
    repeat (7) tick();
    check("t6_eight_retire", RW'(mon_rdata.size() - rb), RW'(8));
    for (int i = 0; i < 8; i++) check($sformatf("t6_res%0d", i), mon_rdata[rb+i], RW'(32'h50 + i));
    check("t6_idle", RW'(idle), RW'(1));
    send_req(32'h4000, 8'd3);
    repeat (2) tick();
    beat(3'd0, 32'h1, RESP_OKAY, 1'b0);
    beat(3'd0, 32'h2, RESP_OKAY, 1'b0);
    rst_n = 1'b0;
    tick();
    check("t7_req_ready", RW'(bus.req_ready), RW'(1));
    check("t7_arvalid", RW'(bus.axi_mst_arvalid), RW'(0));
    check("t7_res_valid", RW'(bus.res_valid), RW'(0));
    check("t7_idle", RW'(idle), RW'(1));
    check("t7_prot", RW'(prot_err), RW'(0));
    rst_n = 1'b1;
    tick();
    beat(3'd0, 32'h3, RESP_OKAY, 1'b1);
    check("t7_stray_prot", RW'(prot_err), RW'(1));
    check("t7_no_res", RW'(bus.res_valid), RW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
